// File: rtl/fft_peak_detect.sv
// fft_peak_detect: strongest-bin search over natural-order FFT spectra.
//
// Consumes one 512-bin spectrum per frame as 16 bins per beat over 32
// consecutive valid beats, computes per-bin power I^2+Q^2 and reports the
// index and power of the strongest bin once per frame.
//
// Ports:
//   clk           clock
//   rstn          asynchronous active-low reset
//   i_valid_in    beat valid, high for 32 consecutive cycles per frame
//   i_din_i       NUM signed WIDTH-bit real parts, lane k at [k*WIDTH +: WIDTH]
//   i_din_q       NUM signed WIDTH-bit imaginary parts, same packing
//   o_peak_valid  one-cycle strobe qualifying o_peak_idx / o_peak_mag
//   o_peak_idx    bin index of the maximum power (held until next strobe)
//   o_peak_mag    unsigned power of that bin (held until next strobe)
//   o_frame_err   one-cycle strobe: frame aborted before its last beat
//
// Configuration:
//   FFT_PEAK_SKIP_DC_EN  when defined, bin 0 power is forced to 0 so DC
//                        never wins the search (all-zero frame -> idx 0).
//
// Pipeline: S1 lane powers -> S2 beat max -> S3 running max -> output
// register, giving 3 clocks from last-beat sample to o_peak_valid.

module fft_peak_detect #(
    parameter int WIDTH       = 13,
    parameter int NUM         = 16,
    parameter int TOTAL_COUNT = 512
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           i_valid_in,
    input  logic [NUM*WIDTH-1:0]           i_din_i,
    input  logic [NUM*WIDTH-1:0]           i_din_q,
    output logic                           o_peak_valid,
    output logic [$clog2(TOTAL_COUNT)-1:0] o_peak_idx,
    output logic [2*WIDTH-1:0]             o_peak_mag,
    output logic                           o_frame_err
);

    localparam int BEATS = TOTAL_COUNT / NUM;
    localparam int BW    = $clog2(BEATS);
    localparam int LW    = $clog2(NUM);
    localparam int IW    = $clog2(TOTAL_COUNT);
    localparam int MW    = 2 * WIDTH;

`ifdef FFT_PEAK_SKIP_DC_EN
    localparam bit SKIP_DC = 1'b1;
`else
    localparam bit SKIP_DC = 1'b0;
`endif

    logic [BW-1:0] r_beat_cnt;

    logic          r_s1_valid;
    logic          r_s1_first;
    logic          r_s1_last;
    logic [BW-1:0] r_s1_beat;
    logic [MW-1:0] r_s1_pow [NUM];

    logic          r_s2_valid;
    logic          r_s2_first;
    logic          r_s2_last;
    logic [MW-1:0] r_s2_mag;
    logic [IW-1:0] r_s2_idx;

    logic          r_s3_done;
    logic [MW-1:0] r_s3_mag;
    logic [IW-1:0] r_s3_idx;

    logic [MW-1:0] w_pow    [NUM];
    logic [MW-1:0] w_t_mag  [LW+1][NUM];
    logic [LW-1:0] w_t_lane [LW+1][NUM];

    // Beat counter wraps naturally at BEATS (a power of two). A low valid
    // mid-frame aborts the frame and rearms for a fresh beat 0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_beat_cnt  <= '0;
            o_frame_err <= 1'b0;
        end else begin
            o_frame_err <= !i_valid_in && (r_beat_cnt != '0);
            r_beat_cnt  <= i_valid_in ? r_beat_cnt + 1'b1 : '0;
        end
    end

    // Per-lane power. Operands are widened before squaring so the product is
    // formed at full width; the unsigned sum of two squares tops out at 2^25
    // and fits in MW bits.
    for (genvar k = 0; k < NUM; k++) begin : g_lane
        logic signed [MW-1:0] w_i;
        logic signed [MW-1:0] w_q;
        logic signed [MW-1:0] w_ii;
        logic signed [MW-1:0] w_qq;
        assign w_i      = MW'($signed(i_din_i[k*WIDTH +: WIDTH]));
        assign w_q      = MW'($signed(i_din_q[k*WIDTH +: WIDTH]));
        assign w_ii     = w_i * w_i;
        assign w_qq     = w_q * w_q;
        assign w_pow[k] = $unsigned(w_ii) + $unsigned(w_qq);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_beat  <= '0;
            for (int k = 0; k < NUM; k++) r_s1_pow[k] <= '0;
        end else begin
            r_s1_valid <= i_valid_in;
            r_s1_first <= (r_beat_cnt == '0);
            r_s1_last  <= (r_beat_cnt == BW'(BEATS - 1));
            r_s1_beat  <= r_beat_cnt;
            for (int k = 0; k < NUM; k++)
                r_s1_pow[k] <= (SKIP_DC && k == 0 && r_beat_cnt == '0) ? '0 : w_pow[k];
        end
    end

    // Pairwise max tree. The right (higher-lane) operand wins only when
    // strictly greater, so ties resolve to the lower bin index.
    always_comb begin
        for (int l = 0; l <= LW; l++) begin
            for (int k = 0; k < NUM; k++) begin
                w_t_mag[l][k]  = '0;
                w_t_lane[l][k] = '0;
            end
        end
        for (int k = 0; k < NUM; k++) begin
            w_t_mag[0][k]  = r_s1_pow[k];
            w_t_lane[0][k] = LW'(k);
        end
        for (int l = 0; l < LW; l++) begin
            for (int k = 0; k < (NUM >> (l + 1)); k++) begin
                w_t_mag[l+1][k]  = (w_t_mag[l][2*k+1] > w_t_mag[l][2*k]) ? w_t_mag[l][2*k+1]  : w_t_mag[l][2*k];
                w_t_lane[l+1][k] = (w_t_mag[l][2*k+1] > w_t_mag[l][2*k]) ? w_t_lane[l][2*k+1] : w_t_lane[l][2*k];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s2_valid <= 1'b0;
            r_s2_first <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_mag   <= '0;
            r_s2_idx   <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            r_s2_first <= r_s1_first;
            r_s2_last  <= r_s1_last;
            r_s2_mag   <= w_t_mag[LW][0];
            r_s2_idx   <= {r_s1_beat, w_t_lane[LW][0]};
        end
    end

    // Running maximum. A first beat reloads unconditionally, which also
    // flushes anything left over from an aborted frame; later beats replace
    // only on strictly greater power so earlier (lower) bins keep ties.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s3_done <= 1'b0;
            r_s3_mag  <= '0;
            r_s3_idx  <= '0;
        end else begin
            r_s3_done <= r_s2_valid && r_s2_last;
            if (r_s2_valid && (r_s2_first || r_s2_mag > r_s3_mag)) begin
                r_s3_mag <= r_s2_mag;
                r_s3_idx <= r_s2_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_peak_valid <= 1'b0;
            o_peak_idx   <= '0;
            o_peak_mag   <= '0;
        end else begin
            o_peak_valid <= r_s3_done;
            if (r_s3_done) begin
                o_peak_idx <= r_s3_idx;
                o_peak_mag <= r_s3_mag;
            end
        end
    end

endmodule

// File: tb/tb_fft_peak_detect.sv
// tb_fft_peak_detect: scenario tests and random frames against a spectrum-level reference model.
module tb_fft_peak_detect;

    localparam int WIDTH = 13;
    localparam int NUM   = 16;
    localparam int TOTAL = 512;
    localparam int BEATS = TOTAL / NUM;

    logic                     clk = 1'b0;
    logic                     rstn = 1'b0;
    logic                     valid = 1'b0;
    logic [NUM*WIDTH-1:0]     din_i = '0;
    logic [NUM*WIDTH-1:0]     din_q = '0;
    logic                     peak_valid;
    logic [$clog2(TOTAL)-1:0] peak_idx;
    logic [2*WIDTH-1:0]       peak_mag;
    logic                     frame_err;

    fft_peak_detect #(.WIDTH(WIDTH), .NUM(NUM), .TOTAL_COUNT(TOTAL)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_valid_in   (valid),
        .i_din_i      (din_i),
        .i_din_q      (din_q),
        .o_peak_valid (peak_valid),
        .o_peak_idx   (peak_idx),
        .o_peak_mag   (peak_mag),
        .o_frame_err  (frame_err)
    );

    int fi [TOTAL];
    int fq [TOTAL];
    int tests_run = 0;
    int fails = 0;
    int cyc = 0;
    int last_cyc = 0;
    int err_cnt = 0;
    int pk_idx_q [$];
    int pk_mag_q [$];
    int pk_cyc_q [$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (peak_valid) begin
            pk_idx_q.push_back(int'(peak_idx));
            pk_mag_q.push_back(int'(peak_mag));
            pk_cyc_q.push_back(cyc);
        end
        if (frame_err) err_cnt <= err_cnt + 1;
    end

    task automatic clear_frame();
        for (int i = 0; i < TOTAL; i++) begin
            fi[i] = 0;
            fq[i] = 0;
        end
    endtask

    task automatic fill_random(input int lo, input int hi);
        for (int i = 0; i < TOTAL; i++) begin
            fi[i] = lo + int'($urandom_range(0, hi - lo));
            fq[i] = lo + int'($urandom_range(0, hi - lo));
        end
    endtask

    // Drives beats 0..n-1 of the current spectrum, one per clock, leaving
    // valid high on the last beat so a following call runs back-to-back.
    task automatic send_beats(input int n);
        for (int b = 0; b < n; b++) begin
            valid = 1'b1;
            for (int k = 0; k < NUM; k++) begin
                din_i[k*WIDTH +: WIDTH] = WIDTH'(fi[b*NUM+k]);
                din_q[k*WIDTH +: WIDTH] = WIDTH'(fq[b*NUM+k]);
            end
            @(negedge clk);
        end
        last_cyc = cyc;
    endtask

    task automatic idle(input int n);
        valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Reference: exhaustive search over the whole spectrum, first maximum wins.
    function automatic void model(output int idx, output int mag);
        int p;
        mag = -1;
        idx = 0;
        for (int i = 0; i < TOTAL; i++) begin
            p = fi[i] * fi[i] + fq[i] * fq[i];
`ifdef FFT_PEAK_SKIP_DC_EN
            if (i == 0) p = 0;
`endif
            if (p > mag) begin
                mag = p;
                idx = i;
            end
        end
    endfunction

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests_run++; if (peak_valid !== 1'b0) begin fails++; $display("FAIL reset_pv: got %b expected 0", peak_valid); end
        tests_run++; if (peak_idx !== '0) begin fails++; $display("FAIL reset_idx: got %0d expected 0", peak_idx); end
        tests_run++; if (peak_mag !== '0) begin fails++; $display("FAIL reset_mag: got %0d expected 0", peak_mag); end
        tests_run++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", frame_err); end
        rstn = 1'b1;
        idle(4);
        tests_run++; if (pk_idx_q.size() != 0 || err_cnt != 0) begin fails++; $display("FAIL reset_idle: got peaks %0d errs %0d expected 0 0", pk_idx_q.size(), err_cnt); end
    endtask

    task automatic test_single_tone();
        int base = pk_idx_q.size();
        clear_frame();
        fi[300] = 100;
        fq[300] = -50;
        send_beats(BEATS);
        idle(8);
        tests_run++;
        if (pk_idx_q.size() != base + 1) begin
            fails++; $display("FAIL tone_count: got %0d expected 1", pk_idx_q.size() - base);
        end else begin
            tests_run++; if (pk_idx_q[base] != 300) begin fails++; $display("FAIL tone_idx: got %0d expected 300", pk_idx_q[base]); end
            tests_run++; if (pk_mag_q[base] != 12500) begin fails++; $display("FAIL tone_mag: got %0d expected 12500", pk_mag_q[base]); end
            tests_run++; if (pk_cyc_q[base] != last_cyc + 3) begin fails++; $display("FAIL tone_latency: got %0d expected 3", pk_cyc_q[base] - last_cyc); end
        end
        tests_run++; if (peak_idx !== 9'd300) begin fails++; $display("FAIL tone_hold: got %0d expected 300", peak_idx); end
    endtask

    task automatic test_tie();
        int base = pk_idx_q.size();
        clear_frame();
        fi[17] = 64;
        fi[400] = 64;
        send_beats(BEATS);
        idle(6);
        tests_run++;
        if (pk_idx_q.size() != base + 1) begin
            fails++; $display("FAIL tie_count: got %0d expected 1", pk_idx_q.size() - base);
        end else begin
            tests_run++; if (pk_idx_q[base] != 17) begin fails++; $display("FAIL tie_idx: got %0d expected 17", pk_idx_q[base]); end
            tests_run++; if (pk_mag_q[base] != 4096) begin fails++; $display("FAIL tie_mag: got %0d expected 4096", pk_mag_q[base]); end
        end
    endtask

    task automatic test_full_scale();
        int base = pk_idx_q.size();
        for (int i = 0; i < TOTAL; i++) begin
            fi[i] = 1;
            fq[i] = 1;
        end
        fi[511] = -4096;
        fq[511] = -4096;
        send_beats(BEATS);
        idle(6);
        tests_run++;
        if (pk_idx_q.size() != base + 1) begin
            fails++; $display("FAIL full_count: got %0d expected 1", pk_idx_q.size() - base);
        end else begin
            tests_run++; if (pk_idx_q[base] != 511) begin fails++; $display("FAIL full_idx: got %0d expected 511", pk_idx_q[base]); end
            tests_run++; if (pk_mag_q[base] != 33554432) begin fails++; $display("FAIL full_mag: got %0d expected 33554432", pk_mag_q[base]); end
        end
    endtask

    task automatic test_back_to_back();
        int base = pk_idx_q.size();
        clear_frame();
        fi[5] = 300;
        send_beats(BEATS);
        clear_frame();
        fi[260] = -700;
        fq[260] = 20;
        send_beats(BEATS);
        idle(6);
        tests_run++;
        if (pk_idx_q.size() != base + 2) begin
            fails++; $display("FAIL b2b_count: got %0d expected 2", pk_idx_q.size() - base);
        end else begin
            tests_run++; if (pk_idx_q[base] != 5) begin fails++; $display("FAIL b2b_idx_a: got %0d expected 5", pk_idx_q[base]); end
            tests_run++; if (pk_mag_q[base] != 90000) begin fails++; $display("FAIL b2b_mag_a: got %0d expected 90000", pk_mag_q[base]); end
            tests_run++; if (pk_idx_q[base+1] != 260) begin fails++; $display("FAIL b2b_idx_b: got %0d expected 260", pk_idx_q[base+1]); end
            tests_run++; if (pk_mag_q[base+1] != 490400) begin fails++; $display("FAIL b2b_mag_b: got %0d expected 490400", pk_mag_q[base+1]); end
            tests_run++; if (pk_cyc_q[base+1] - pk_cyc_q[base] != 32) begin fails++; $display("FAIL b2b_spacing: got %0d expected 32", pk_cyc_q[base+1] - pk_cyc_q[base]); end
        end
    endtask

    task automatic test_abort();
        int base = pk_idx_q.size();
        int e0 = err_cnt;
        int exp_idx, exp_mag;
        fill_random(-3, 3);
        fi[40] = 2000;
        send_beats(10);
        idle(4);
        tests_run++; if (err_cnt != e0 + 1) begin fails++; $display("FAIL abort_err: got %0d expected 1", err_cnt - e0); end
        tests_run++; if (pk_idx_q.size() != base) begin fails++; $display("FAIL abort_nopeak: got %0d expected 0", pk_idx_q.size() - base); end
        fill_random(-3, 3);
        fi[33] = 1000;
        model(exp_idx, exp_mag);
        send_beats(BEATS);
        idle(6);
        tests_run++;
        if (pk_idx_q.size() != base + 1) begin
            fails++; $display("FAIL abort_next_count: got %0d expected 1", pk_idx_q.size() - base);
        end else begin
            tests_run++; if (pk_idx_q[base] != 33) begin fails++; $display("FAIL abort_next_idx: got %0d expected 33", pk_idx_q[base]); end
            tests_run++; if (pk_mag_q[base] != exp_mag) begin fails++; $display("FAIL abort_next_mag: got %0d expected %0d", pk_mag_q[base], exp_mag); end
        end
        tests_run++; if (err_cnt != e0 + 1) begin fails++; $display("FAIL abort_err_total: got %0d expected 1", err_cnt - e0); end
    endtask

    task automatic test_reset_mid_frame();
        int base, e0;
        int exp_idx, exp_mag;
        fill_random(-3, 3);
        fi[100] = 800;
        send_beats(20);
        rstn = 1'b0;
        valid = 1'b0;
        @(negedge clk);
        tests_run++; if (peak_idx !== '0 || peak_mag !== '0) begin fails++; $display("FAIL rst_mid_out: got idx %0d mag %0d expected 0 0", peak_idx, peak_mag); end
        tests_run++; if (peak_valid !== 1'b0 || frame_err !== 1'b0) begin fails++; $display("FAIL rst_mid_strobes: got pv %b err %b expected 0 0", peak_valid, frame_err); end
        rstn = 1'b1;
        idle(2);
        base = pk_idx_q.size();
        e0 = err_cnt;
        fill_random(-3, 3);
        fq[77] = -1500;
        model(exp_idx, exp_mag);
        send_beats(BEATS);
        idle(6);
        tests_run++;
        if (pk_idx_q.size() != base + 1) begin
            fails++; $display("FAIL rst_next_count: got %0d expected 1", pk_idx_q.size() - base);
        end else begin
            tests_run++; if (pk_idx_q[base] != exp_idx) begin fails++; $display("FAIL rst_next_idx: got %0d expected %0d", pk_idx_q[base], exp_idx); end
            tests_run++; if (pk_mag_q[base] != exp_mag) begin fails++; $display("FAIL rst_next_mag: got %0d expected %0d", pk_mag_q[base], exp_mag); end
        end
        tests_run++; if (err_cnt != e0) begin fails++; $display("FAIL rst_next_err: got %0d expected 0", err_cnt - e0); end
    endtask

    task automatic test_dc();
        int base = pk_idx_q.size();
        int exp_idx, exp_mag;
`ifdef FFT_PEAK_SKIP_DC_EN
        exp_idx = 8;
        exp_mag = 100;
`else
        exp_idx = 0;
        exp_mag = 4000000;
`endif
        clear_frame();
        fi[0] = 2000;
        fi[8] = 10;
        send_beats(BEATS);
        idle(6);
        tests_run++;
        if (pk_idx_q.size() != base + 1) begin
            fails++; $display("FAIL dc_count: got %0d expected 1", pk_idx_q.size() - base);
        end else begin
            tests_run++; if (pk_idx_q[base] != exp_idx) begin fails++; $display("FAIL dc_idx: got %0d expected %0d", pk_idx_q[base], exp_idx); end
            tests_run++; if (pk_mag_q[base] != exp_mag) begin fails++; $display("FAIL dc_mag: got %0d expected %0d", pk_mag_q[base], exp_mag); end
        end
    endtask

    // Back-to-back random frames; even frames use full-range samples, odd
    // frames a tiny range so ties across lanes and beats are common.
    task automatic test_random();
        int base = pk_idx_q.size();
        int exp_idx [$];
        int exp_mag [$];
        int ei, em;
        for (int f = 0; f < 6; f++) begin
            if (f % 2 == 0) fill_random(-4096, 4095);
            else fill_random(-1, 1);
            model(ei, em);
            exp_idx.push_back(ei);
            exp_mag.push_back(em);
            send_beats(BEATS);
        end
        idle(6);
        tests_run++;
        if (pk_idx_q.size() != base + 6) begin
            fails++; $display("FAIL rand_count: got %0d expected 6", pk_idx_q.size() - base);
        end else begin
            for (int f = 0; f < 6; f++) begin
                tests_run++; if (pk_idx_q[base+f] != exp_idx[f]) begin fails++; $display("FAIL rand_idx[%0d]: got %0d expected %0d", f, pk_idx_q[base+f], exp_idx[f]); end
                tests_run++; if (pk_mag_q[base+f] != exp_mag[f]) begin fails++; $display("FAIL rand_mag[%0d]: got %0d expected %0d", f, pk_mag_q[base+f], exp_mag[f]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_tone();
        test_tie();
        test_full_scale();
        test_back_to_back();
        test_abort();
        test_reset_mid_frame();
        test_dc();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/fft_peak_detect.md
# fft_peak_detect

Downstream of the FFT output reorder stage. Consumes each natural-order 512-bin spectrum, arriving as 16 bins per beat over 32 consecutive valid beats. Computes per-bin power I²+Q² and reports the bin index and power of the strongest bin once per frame. Feeds the control/report logic with a single-cycle result strobe.

## Interface
- WIDTH, 13, signed bit width of each I/Q sample (<9.4> format)
- NUM, 16, bins per input beat (lanes)
- TOTAL_COUNT, 512, bins per frame; beats per frame = TOTAL_COUNT/NUM = 32

- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- valid_in  in  1  beat valid; high for exactly 32 consecutive cycles per frame
- din_i  in  signed [WIDTH-1:0] x NUM  real parts; lane k = bin beat*NUM+k
- din_q  in  signed [WIDTH-1:0] x NUM  imaginary parts
- peak_valid  out  1  one-cycle strobe: peak_idx and peak_mag valid
- peak_idx  out  [$clog2(TOTAL_COUNT)-1:0]  bin index of the maximum power
- peak_mag  out  [2*WIDTH-1:0]  unsigned power of that bin
- frame_err  out  1  one-cycle strobe: frame aborted (short frame)

## Operation
- Beat counter beat_cnt, $clog2(TOTAL_COUNT/NUM) bits. Increments on every valid_in beat and wraps 31→0. Beat with beat_cnt==0 is first; beat with beat_cnt==31 is last.
- Back-to-back frames (valid_in held 64 cycles) are two frames; no gap required.
- Power: p = i*i + q*q. Computed in 2*WIDTH bits unsigned; cannot overflow (max 2·4096² = 2^25).
- S1 (registered): 16 lane powers, beat index, first/last flags, stage valid.
- S2 (registered): combinational 16→1 max tree over S1 lanes. Registers beat max power and bin index = beat*NUM + lane.
- S3 (registered): running maximum.
  - On first-beat data: load unconditionally.
  - Otherwise: replace only if strictly greater.
  - Ties in the tree and across beats go to the lower bin index.
- On last-beat data in S3, the final result is registered to peak_idx/peak_mag and peak_valid pulses for 1 cycle.
- peak_idx and peak_mag hold their value until the next peak_valid.
- Short frame: valid_in sampled low while beat_cnt != 0.
  - beat_cnt returns to 0 and frame_err pulses 1 cycle.
  - No peak_valid is produced for that frame.
  - In-flight beats of the aborted frame are harmless: the next first-beat reloads S3.
- Reset values: peak_valid=0, peak_idx=0, peak_mag=0, frame_err=0, beat_cnt=0, all pipeline valids=0.
- Reset asserted mid-frame discards the frame. The first valid beat after reset release is beat 0.

## Timing
- Last beat sampled at edge T → peak_valid high in the cycle following edge T+3 (latency 3 clocks).
- Throughput: one beat per clock, no stalls, no backpressure.
- frame_err high in the cycle after the edge that samples the abort (1-clock latency).
- An abort and an in-flight peak_valid of the previous complete frame may coincide; both strobes assert independently.
- Minimum inter-frame gap 0 cycles. peak_valid strobes are therefore spaced ≥32 cycles apart.

## Configuration
- FFT_PEAK_SKIP_DC_EN defined: the bin 0 power (lane 0 of beat 0) is forced to 0 before S2, excluding DC from the search.
  - If all other bins are also 0, the result is idx 0, mag 0.
- FFT_PEAK_SKIP_DC_EN undefined: bin 0 participates like any other bin.

## Test plan
- Single tone: bin 300 = (I=100, Q=-50), all others 0 → peak_valid 3 cycles after beat 31, peak_idx=300, peak_mag=12500.
- Tie: bins 17 and 400 both (I=64, Q=0) → peak_idx=17, peak_mag=4096.
- Full scale: bin 511 = (−4096, −4096), others (1,1) → peak_idx=511, peak_mag=33554432, no overflow.
- Back-to-back: frame A peak bin 5, frame B peak bin 260, valid held 64 cycles → two peak_valid strobes 32 cycles apart, idx 5 then 260.
- Abort: valid_in drops after 10 beats, then a full frame with peak bin 33 → one frame_err pulse, no peak for the aborted frame, then peak_idx=33. Repeat with rstn pulsed at beat 20 → all outputs 0, then next frame correct.
- DC: bin 0 = (2000, 0), bin 8 = (10, 0) → peak_idx=0 without FFT_PEAK_SKIP_DC_EN; peak_idx=8, peak_mag=100 with it.
